// File: rtl/circuit_scan.sv
// rtl/circuit_scan.sv - scan-testable shift state register with match flag and saturating match counter
module circuit_scan #(
  parameter int             N     = 4,
  parameter int             W     = 3,
  parameter logic [N-1:0]   MATCH = 4'b1011,
  parameter int             CW    = 8
) (
  input  logic          CP,
  input  logic          CLRn,
  input  logic [W-1:0]  x,
  input  logic          SET,
  input  logic          SE,
  input  logic          SI,
  output logic          z,
  output logic          SO,
  output logic [CW-1:0] match_cnt
);

  logic [N-1:0] state;
  logic         fb;
  logic         cnt_full;

  // Functional feedback bit: parity of the data inputs folded with the outgoing MSB
  always_comb begin
    fb = (^x) ^ state[N-1];
  end

  // Moore outputs taken straight from the state register; SO is the scan chain tail
  always_comb begin
    z        = (state == MATCH);
    SO       = state[N-1];
    cnt_full = (match_cnt == {CW{1'b1}});
  end

  // State register: clear > set > scan shift > functional shift
  always_ff @(posedge CP or negedge CLRn) begin
    if (!CLRn) begin
      state <= '0;
    end else if (SET) begin
      state <= '1;
    end else if (SE) begin
      state <= {state[N-2:0], SI};
    end else begin
      state <= {state[N-2:0], fb};
    end
  end

  // Match counter: counts functional edges seen with z high, saturating, cleared by SET
  always_ff @(posedge CP or negedge CLRn) begin
    if (!CLRn) begin
      match_cnt <= '0;
    end else if (SET) begin
      match_cnt <= '0;
    end else if (!SE && z && !cnt_full) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_circuit_scan.sv
// tb/tb_circuit_scan.sv - self-checking bench for circuit_scan against a behavioural model
module tb_circuit_scan;

  logic       CP;
  logic       CLRn;
  logic [2:0] x;
  logic       SET;
  logic       SE;
  logic       SI;
  logic       z;
  logic       SO;
  logic [7:0] match_cnt;
  logic       z2;
  logic       so2;
  logic [1:0] match_cnt2;

  int checks;
  int failures;

  // behavioural model: state value, counter for CW=8 and counter for CW=2
  int ms;
  int mc;
  int mc2;

  circuit_scan u_dut (
    .CP(CP), .CLRn(CLRn), .x(x), .SET(SET), .SE(SE), .SI(SI),
    .z(z), .SO(SO), .match_cnt(match_cnt)
  );

  circuit_scan #(.CW(2)) u_sat (
    .CP(CP), .CLRn(CLRn), .x(x), .SET(SET), .SE(SE), .SI(SI),
    .z(z2), .SO(so2), .match_cnt(match_cnt2)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_state"}, {28'd0, u_dut.state}, ms);
    check({tag, "_z"}, {31'd0, z}, (ms == 11) ? 1 : 0);
    check({tag, "_so"}, {31'd0, SO}, (ms >> 3) & 1);
    check({tag, "_cnt"}, {24'd0, match_cnt}, mc);
    check({tag, "_cnt2"}, {30'd0, match_cnt2}, mc2);
    check({tag, "_state2"}, {28'd0, u_sat.state}, ms);
  endtask

  task automatic model_reset();
    ms  = 0;
    mc  = 0;
    mc2 = 0;
  endtask

  // One clock edge with the given inputs; model advanced from the pre-edge state
  task automatic step(input string tag, input logic set_i, input logic se_i,
                      input logic si_i, input logic [2:0] x_i);
    int b;
    SET = set_i;
    SE  = se_i;
    SI  = si_i;
    x   = x_i;
    @(posedge CP);
    if (set_i) begin
      ms  = 15;
      mc  = 0;
      mc2 = 0;
    end else if (se_i) begin
      ms = ((ms << 1) | int'(si_i)) & 15;
    end else begin
      b = ($countones(x_i) % 2) ^ ((ms >> 3) & 1);
      if (ms == 11) begin
        if (mc < 255) mc++;
        if (mc2 < 3) mc2++;
      end
      ms = ((ms << 1) | b) & 15;
    end
    #1;
    check_all(tag);
  endtask

  // Asserted away from edges; verifies immediate clear and that edges are ignored while low
  task automatic do_reset(input string tag);
    CLRn = 1'b0;
    #1;
    model_reset();
    check_all({tag, "_async"});
    repeat (2) begin
      SET = 1'($urandom);
      SE  = 1'($urandom);
      SI  = 1'($urandom);
      x   = 3'($urandom);
      @(posedge CP);
      #1;
      check_all({tag, "_held"});
    end
    CLRn = 1'b1;
  endtask

  task automatic scan_load_1011(input string tag);
    step({tag, "_s1"}, 1'b0, 1'b1, 1'b1, 3'($urandom));
    step({tag, "_s2"}, 1'b0, 1'b1, 1'b0, 3'($urandom));
    step({tag, "_s3"}, 1'b0, 1'b1, 1'b1, 3'($urandom));
    step({tag, "_s4"}, 1'b0, 1'b1, 1'b1, 3'($urandom));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    CLRn = 1'b0;
    SET  = 1'b0;
    SE   = 1'b0;
    SI   = 1'b0;
    x    = 3'd0;
    model_reset();
    @(posedge CP);
    #1;

    // reset behaviour with the clock running
    do_reset("rst");

    // scan load from reset
    scan_load_1011("scan");
    check("scan_z_direct", {31'd0, z}, 1);
    check("scan_cnt_zero", {24'd0, match_cnt}, 0);

    // functional sequence from reset, fifth edge records the match
    do_reset("rst2");
    step("fn1", 1'b0, 1'b0, 1'b0, 3'b001);
    step("fn2", 1'b0, 1'b0, 1'b0, 3'b000);
    step("fn3", 1'b0, 1'b0, 1'b0, 3'b001);
    step("fn4", 1'b0, 1'b0, 1'b0, 3'b001);
    check("fn_match_state", {28'd0, u_dut.state}, 11);
    step("fn5", 1'b0, 1'b0, 1'b0, 3'b000);
    check("fn5_state", {28'd0, u_dut.state}, 7);
    check("fn5_cnt", {24'd0, match_cnt}, 1);

    // build the count to 5 (CW=2 copy saturates at 3 along the way)
    for (int i = 0; i < 4; i++) begin
      scan_load_1011("reload");
      step("count", 1'b0, 1'b0, 1'b0, 3'($urandom));
    end
    check("cnt_five", {24'd0, match_cnt}, 5);
    check("cnt2_saturated", {30'd0, match_cnt2}, 3);

    // set wins over scan enable
    scan_load_1011("preset");
    step("set_prio", 1'b1, 1'b1, 1'b0, 3'($urandom));
    check("set_state", {28'd0, u_dut.state}, 15);
    check("set_cnt", {24'd0, match_cnt}, 0);

    // asynchronous reset in the middle of a scan
    do_reset("rst3");
    step("mid1", 1'b0, 1'b1, 1'b1, 3'($urandom));
    step("mid2", 1'b0, 1'b1, 1'b0, 3'($urandom));
    CLRn = 1'b0;
    #2;
    model_reset();
    check_all("mid_pulse");
    CLRn = 1'b1;
    step("mid_after", 1'b0, 1'b1, 1'b1, 3'($urandom));
    check("mid_after_state", {28'd0, u_dut.state}, 1);

    // randomized traffic, biased towards functional mode so matches occur
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
             1'($urandom), 3'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
